// File: rtl/sum_accumulator.sv
// sum_accumulator
//
// Sums LEN consecutive 9-bit adder results ({cout, sum}) into an ACC_W-bit
// running total. Operands arrive on a valid/ready handshake. The finished
// block total is held behind an output valid/ready handshake.
//
// Build option:
//   SUM_ACCUMULATOR_SATURATE_EN  - when defined, the total clamps at all ones
//                                  on overflow. Otherwise it wraps modulo
//                                  2^ACC_W. ovf flags either event.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a block (taken in IDLE, or in DONE together with out_ready)
//   in_valid   upstream adder result valid
//   in_ready   accepting a result this cycle (ACCUM only)
//   sum_in     adder sum [7:0]
//   cout_in    adder carry-out
//   out_valid  acc_out holds a completed block total (DONE)
//   out_ready  downstream accepts the total
//   acc_out    running / final total [ACC_W-1:0]
//   count      results accepted in the current block [CNT_W-1:0]
//   ovf        sticky overflow flag for the current block
//   busy       high in ACCUM and DONE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; previous block results remain visible
// ACCUM | accepting operands until LEN have been summed
// DONE  | total presented; held until out_ready

module sum_accumulator #(
    parameter int ACC_W = 16,
    parameter int LEN   = 4,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       sum_in,
    input  logic             cout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_t           state_q;
    state_t           state_d;
    logic             xfer;
    logic             last;
    logic             clear;
    logic [ACC_W-1:0] operand;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_d;

    assign operand  = {{(ACC_W - 9){1'b0}}, cout_in, sum_in};
    assign xfer     = in_valid && (state_q == S_ACCUM);
    assign last     = (count == LAST_IDX);
    // A block restarts from IDLE, or straight out of DONE when the total is
    // taken in the same cycle (back-to-back blocks).
    assign clear    = start && ((state_q == S_IDLE) ||
                                ((state_q == S_DONE) && out_ready));
    // One extra bit so the carry out of the total is visible for ovf.
    assign sum_wide = {1'b0, acc_out} + {1'b0, operand};

`ifdef SUM_ACCUMULATOR_SATURATE_EN
    // Once clamped, any further add either carries again or adds zero, so the
    // total stays at all ones for the rest of the block.
    assign acc_d = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
`else
    assign acc_d = sum_wide[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (xfer && last) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = start ? S_ACCUM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                acc_out <= '0;
                count   <= '0;
                ovf     <= 1'b0;
            end else if (xfer) begin
                acc_out <= acc_d;
                count   <= count + CNT_W'(1);
                ovf     <= ovf | sum_wide[ACC_W];
            end
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator. Two instances (ACC_W=16 and
// ACC_W=10, both LEN=4) share all inputs so the wide one checks plain
// summation while the narrow one exercises overflow.
module tb_sum_accumulator;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [7:0] sum_in;
    logic       cout_in;
    logic       out_ready;

    logic        in_ready16, out_valid16, ovf16, busy16;
    logic [15:0] acc16;
    logic [2:0]  count16;
    logic        in_ready10, out_valid10, ovf10, busy10;
    logic [9:0]  acc10;
    logic [2:0]  count10;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.ACC_W(16), .LEN(LEN)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready16), .sum_in(sum_in), .cout_in(cout_in),
        .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc16),
        .count(count16), .ovf(ovf16), .busy(busy16)
    );

    sum_accumulator #(.ACC_W(10), .LEN(LEN)) u10 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready10), .sum_in(sum_in), .cout_in(cout_in),
        .out_valid(out_valid10), .out_ready(out_ready), .acc_out(acc10),
        .count(count10), .ovf(ovf10), .busy(busy10)
    );

    typedef struct {
        int     ops[4];
        longint e16;
        bit     o16;
        longint e10;
        bit     o10;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the block total is just the arithmetic sum of the operands,
    // then wrapped or clamped to the accumulator width.
    function automatic void model(input int ops[4], input int w,
                                  output longint acc, output bit ovf);
        longint total = 0;
        longint maxv  = (longint'(1) << w) - 1;
        foreach (ops[i]) total += ops[i];
        ovf = (total > maxv);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        acc = ovf ? maxv : total;
`else
        acc = total % (maxv + 1);
`endif
    endfunction

    // Drives one block into DONE. gap_mode: 0 back-to-back, 1 alternate idle
    // cycles, 2 random idle cycles.
    task automatic feed_block(input int ops[4], input int gap_mode, input bit do_start,
                              input longint e16, input bit o16,
                              input longint e10, input bit o10);
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk("start_acc", acc16, 0);
            chk("start_cnt", count16, 0);
            chk("start_ovf10", ovf10, 0);
            chk("start_rdy", in_ready16, 1);
            chk("start_busy", busy16, 1);
        end
        for (int i = 0; i < LEN; i++) begin
            int g;
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                {cout_in, sum_in} = 9'($urandom_range(0, 511));
                step();
                chk("gap_rdy", in_ready16, 1);
                chk("gap_cnt", count16, i);
            end
            in_valid = 1'b1;
            {cout_in, sum_in} = 9'(ops[i]);
            step();
            in_valid = 1'b0;
            if (i < LEN - 1) chk("mid_ovalid", out_valid16, 0);
        end
        chk("done_ovalid", out_valid16, 1);
        chk("done_rdy", in_ready16, 0);
        chk("done_cnt", count16, LEN);
        chk("done_acc16", acc16, e16);
        chk("done_ovf16", ovf16, o16);
        chk("done_acc10", acc10, e10);
        chk("done_ovf10", ovf10, o10);
        chk("done_ovalid10", out_valid10, 1);
    endtask

    task automatic release_out(input longint e16);
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rel_ovalid", out_valid16, 0);
        chk("rel_busy", busy16, 0);
        chk("rel_acc_held", acc16, e16);
        chk("rel_cnt_held", count16, LEN);
    endtask

    initial begin
        int plan[4];
        int bp2[4];
        longint e16, e10;
        bit o16, o10;

        plan = '{396, 397, 12, 13};
        vecs[0] = '{ops: '{396, 397, 12, 13}, e16: 818,  o16: 0, e10: 818, o10: 0};
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        vecs[1] = '{ops: '{511, 511, 511, 511}, e16: 2044, o16: 0, e10: 1023, o10: 1};
        vecs[3] = '{ops: '{300, 300, 300, 300}, e16: 1200, o16: 0, e10: 1023, o10: 1};
        vecs[5] = '{ops: '{511, 511, 2, 0},     e16: 1024, o16: 0, e10: 1023, o10: 1};
`else
        vecs[1] = '{ops: '{511, 511, 511, 511}, e16: 2044, o16: 0, e10: 1020, o10: 1};
        vecs[3] = '{ops: '{300, 300, 300, 300}, e16: 1200, o16: 0, e10: 176,  o10: 1};
        vecs[5] = '{ops: '{511, 511, 2, 0},     e16: 1024, o16: 0, e10: 0,    o10: 1};
`endif
        vecs[2] = '{ops: '{0, 0, 0, 0},         e16: 0,    o16: 0, e10: 0,    o10: 0};
        vecs[4] = '{ops: '{511, 511, 1, 0},     e16: 1023, o16: 0, e10: 1023, o10: 0};

        // Reset with random inputs
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            start     = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            {cout_in, sum_in} = 9'($urandom);
            step();
        end
        chk("rst_acc", acc16, 0);
        chk("rst_cnt", count16, 0);
        chk("rst_ovf", ovf16, 0);
        chk("rst_ovalid", out_valid16, 0);
        chk("rst_rdy", in_ready16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_acc10", acc10, 0);
        rst_n = 1'b1;
        start = 1'b0; out_ready = 1'b0;

        // IDLE ignores in_valid
        in_valid = 1'b1; {cout_in, sum_in} = 9'd100;
        step();
        in_valid = 1'b0;
        chk("idle_cnt", count16, 0);
        chk("idle_acc", acc16, 0);
        chk("idle_rdy", in_ready16, 0);

        // Table vectors, back-to-back operands
        for (int v = 0; v < 6; v++) begin
            feed_block(vecs[v].ops, 0, 1'b1, vecs[v].e16, vecs[v].o16,
                       vecs[v].e10, vecs[v].o10);
            release_out(vecs[v].e16);
        end

        // Alternate-cycle in_valid
        feed_block(plan, 1, 1'b1, 818, 0, 818, 0);
        release_out(818);

        // Backpressure in DONE, then back-to-back start
        feed_block(plan, 0, 1'b1, 818, 0, 818, 0);
        for (int k = 0; k < 10; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            start     = k[0];
            step();
            chk("bp_ovalid", out_valid16, 1);
            chk("bp_acc", acc16, 818);
            chk("bp_rdy", in_ready16, 0);
            chk("bp_cnt", count16, LEN);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("b2b_ovalid", out_valid16, 0);
        chk("b2b_rdy", in_ready16, 1);
        chk("b2b_acc", acc16, 0);
        chk("b2b_cnt", count16, 0);
        chk("b2b_busy", busy16, 1);
        bp2 = '{511, 511, 511, 511};
        model(bp2, 16, e16, o16);
        model(bp2, 10, e10, o10);
        feed_block(bp2, 0, 1'b0, e16, o16, e10, o10);
        release_out(e16);

        // Reset mid-block after two operands
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            {cout_in, sum_in} = 9'(200 + i);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_cnt", count16, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_acc", acc16, 0);
        chk("mrst_cnt", count16, 0);
        chk("mrst_rdy", in_ready16, 0);
        chk("mrst_busy", busy16, 0);
        step();
        chk("mrst_ovalid", out_valid16, 0);
        feed_block(plan, 0, 1'b1, 818, 0, 818, 0);
        release_out(818);

        // Random blocks against the arithmetic model
        for (int b = 0; b < 20; b++) begin
            int rops[4];
            int hold;
            foreach (rops[i]) rops[i] = int'($urandom_range(0, 511));
            model(rops, 16, e16, o16);
            model(rops, 10, e10, o10);
            feed_block(rops, 2, 1'b1, e16, o16, e10, o10);
            hold = int'($urandom_range(0, 3));
            for (int k = 0; k < hold; k++) begin
                out_ready = 1'b0;
                start     = 1'($urandom);
                step();
                chk("rnd_hold_ovalid", out_valid16, 1);
                chk("rnd_hold_acc10", acc10, e10);
            end
            release_out(e16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
